// File: rtl/rom_byte_streamer_if.sv
// rtl/rom_byte_streamer_if.sv - command, ROM and byte-stream signals of the ROM byte streamer
interface rom_byte_streamer_if #(
  parameter int ADDR_W = 8,
  parameter int LEN_W  = 11
);
  logic                start;
  logic [ADDR_W+1:0]   start_badr;
  logic [LEN_W-1:0]    len;
  logic                abort;
  logic [ADDR_W-1:0]   rom_adr;
  logic [31:0]         rom_data;
  logic                out_valid;
  logic                out_ready;
  logic [7:0]          out_byte;
  logic [ADDR_W+1:0]   out_badr;
  logic                busy;
  logic                done;

  modport master (
    output start, start_badr, len, abort, rom_data, out_ready,
    input  rom_adr, out_valid, out_byte, out_badr, busy, done
  );

  modport slave (
    input  start, start_badr, len, abort, rom_data, out_ready,
    output rom_adr, out_valid, out_byte, out_badr, busy, done
  );
endinterface

// File: rtl/rom_byte_streamer.sv
// rtl/rom_byte_streamer.sv - walks a byte range of a 32-bit async ROM, one word fetch per 4 bytes
module rom_byte_streamer #(
  parameter int ADDR_W = 8,
  parameter int LEN_W  = 11
) (
  input logic               clk,
  input logic               rst,
  rom_byte_streamer_if.slave bus
);
  localparam int BA_W = ADDR_W + 2;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_FETCH  = 2'd1;
  localparam logic [1:0] S_STREAM = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [BA_W-1:0]  cur_badr_q, cur_badr_d;
  logic [LEN_W-1:0] remaining_q, remaining_d;
  logic [31:0]      word_q, word_d;
  logic             accept;

  assign accept = (state_q == S_STREAM) && bus.out_ready;

  always_comb begin
    state_d     = state_q;
    cur_badr_d  = cur_badr_q;
    remaining_d = remaining_q;
    word_d      = word_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          if (bus.len != '0) begin
            cur_badr_d  = bus.start_badr;
            remaining_d = bus.len;
            state_d     = S_FETCH;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_FETCH: begin
        word_d  = bus.rom_data;
        state_d = S_STREAM;
      end
      S_STREAM: begin
        if (accept) begin
          cur_badr_d  = cur_badr_q + BA_W'(1);
          remaining_d = remaining_q - LEN_W'(1);
          // Last byte wins over a word boundary: no useless fetch at the end.
          if (remaining_q == LEN_W'(1)) begin
            state_d = S_DONE;
          end else if (cur_badr_q[1:0] == 2'b11) begin
            state_d = S_FETCH;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    // Abort discards any same-cycle accept so the partial byte is not consumed.
    if (bus.abort && (state_q != S_IDLE)) begin
      state_d     = S_IDLE;
      cur_badr_d  = cur_badr_q;
      remaining_d = remaining_q;
      word_d      = word_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cur_badr_q  <= '0;
      remaining_q <= '0;
      word_q      <= '0;
    end else begin
      state_q     <= state_d;
      cur_badr_q  <= cur_badr_d;
      remaining_q <= remaining_d;
      word_q      <= word_d;
    end
  end

  assign bus.rom_adr   = cur_badr_q[BA_W-1:2];
  assign bus.out_valid = (state_q == S_STREAM);
  assign bus.out_byte  = word_q[{cur_badr_q[1:0], 3'b000} +: 8];
  assign bus.out_badr  = cur_badr_q;
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.done      = (state_q == S_DONE);
endmodule
